// File: rtl/vin_matrix_sel_ctrl_if.sv
// Host/matrix-side signal bundle for the video matrix switch controller.
// The slave side is the controller; the master side drives requests and sync streams.
interface vin_matrix_sel_ctrl_if;
  logic       cfg_wr;
  logic [1:0] cfg_out;
  logic [2:0] cfg_src;
  logic       cfg_err;
  logic [4:0] vs_in;
  logic [3:0] vout_vs;
  logic [2:0] sel_ch0;
  logic [2:0] sel_ch1;
  logic [2:0] sel_ch2;
  logic [2:0] sel_ch3;
  logic [3:0] sel_pending;
  logic [3:0] sel_done;
  logic [3:0] sel_timeout;
  logic [4:0] sig_present;

  modport master (
    output cfg_wr, cfg_out, cfg_src, vs_in, vout_vs,
    input  cfg_err, sel_ch0, sel_ch1, sel_ch2, sel_ch3,
           sel_pending, sel_done, sel_timeout, sig_present
  );

  modport slave (
    input  cfg_wr, cfg_out, cfg_src, vs_in, vout_vs,
    output cfg_err, sel_ch0, sel_ch1, sel_ch2, sel_ch3,
           sel_pending, sel_done, sel_timeout, sig_present
  );
endinterface

// File: rtl/vin_matrix_sel_ctrl.sv
// Frame-aligned route switching for the 5-in/4-out video matrix, with per-output
// sync-loss timeout and per-input signal presence detection.
module vin_matrix_sel_ctrl #(
  parameter logic                 VS_POL    = 1'b1,
  parameter int unsigned          TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'd2000000
) (
  input  logic                  clk,
  input  logic                  rst,
  vin_matrix_sel_ctrl_if.slave  bus
);

  localparam logic [TIMEOUT_W-1:0] LP_TMAX      = TIMEOUT - TIMEOUT_W'(1);
  localparam logic [3:0]           LP_VOUT_IDLE = {4{~VS_POL}};
  localparam logic [4:0]           LP_VIN_IDLE  = {5{~VS_POL}};
  localparam logic [2:0]           LP_MAX_SRC   = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t               r_state     [4];
  state_t               w_state_nxt [4];
  logic [2:0]           r_sel       [4];
  logic [2:0]           w_sel_nxt   [4];
  logic [2:0]           r_tgt       [4];
  logic [2:0]           w_tgt_nxt   [4];
  logic [TIMEOUT_W-1:0] r_cnt       [4];
  logic [TIMEOUT_W-1:0] w_cnt_nxt   [4];
  logic [3:0]           r_done;
  logic [3:0]           w_done_nxt;
  logic [3:0]           r_tmo;
  logic [3:0]           w_tmo_nxt;
  logic [3:0]           r_vout_vs_d;
  logic [3:0]           w_fs_out;
  logic [3:0]           w_wr_out;
  logic                 r_err;
  logic                 w_src_ok;
  logic [4:0]           r_vs_in_d;
  logic [4:0]           w_fs_in;
  logic [4:0]           r_present;
  logic [TIMEOUT_W-1:0] r_pcnt      [5];

  assign w_src_ok = (bus.cfg_src <= LP_MAX_SRC);

  // Frame start = first cycle vs sits at its active level.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_fs_out[n] = (bus.vout_vs[n] == VS_POL) && (r_vout_vs_d[n] != VS_POL);
      w_wr_out[n] = bus.cfg_wr && w_src_ok && (bus.cfg_out == 2'(n));
    end
    for (int m = 0; m < 5; m++) begin
      w_fs_in[m] = (bus.vs_in[m] == VS_POL) && (r_vs_in_d[m] != VS_POL);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_state_nxt[n] = r_state[n];
      w_sel_nxt[n]   = r_sel[n];
      w_tgt_nxt[n]   = r_tgt[n];
      w_cnt_nxt[n]   = r_cnt[n];
      w_done_nxt[n]  = 1'b0;
      w_tmo_nxt[n]   = 1'b0;
      case (r_state[n])
        ST_IDLE: begin
          if (w_wr_out[n]) begin
            if (bus.cfg_src == r_sel[n]) begin
              w_done_nxt[n] = 1'b1;
            end else begin
              w_state_nxt[n] = ST_WAIT;
              w_tgt_nxt[n]   = bus.cfg_src;
              w_cnt_nxt[n]   = '0;
            end
          end
        end
        ST_WAIT: begin
          w_cnt_nxt[n] = r_cnt[n] + TIMEOUT_W'(1);
          if (w_wr_out[n]) begin
            w_tgt_nxt[n] = bus.cfg_src;
          end
          // A write landing on the boundary cycle wins over the stored target.
          if (w_fs_out[n] || (r_cnt[n] == LP_TMAX)) begin
            w_sel_nxt[n]   = w_wr_out[n] ? bus.cfg_src : r_tgt[n];
            w_done_nxt[n]  = 1'b1;
            w_tmo_nxt[n]   = !w_fs_out[n];
            w_state_nxt[n] = ST_IDLE;
          end
        end
        default: w_state_nxt[n] = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        r_state[n] <= ST_IDLE;
        r_sel[n]   <= 3'(n);
        r_tgt[n]   <= '0;
        r_cnt[n]   <= '0;
      end
      r_done      <= '0;
      r_tmo       <= '0;
      r_err       <= 1'b0;
      r_vout_vs_d <= LP_VOUT_IDLE;
    end else begin
      for (int n = 0; n < 4; n++) begin
        r_state[n] <= w_state_nxt[n];
        r_sel[n]   <= w_sel_nxt[n];
        r_tgt[n]   <= w_tgt_nxt[n];
        r_cnt[n]   <= w_cnt_nxt[n];
      end
      r_done      <= w_done_nxt;
      r_tmo       <= w_tmo_nxt;
      r_err       <= bus.cfg_wr && !w_src_ok;
      r_vout_vs_d <= bus.vout_vs;
    end
  end

  // Presence: drop once a full TIMEOUT window passes without a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_in_d <= LP_VIN_IDLE;
      r_present <= '0;
      for (int m = 0; m < 5; m++) begin
        r_pcnt[m] <= '0;
      end
    end else begin
      r_vs_in_d <= bus.vs_in;
      for (int m = 0; m < 5; m++) begin
        if (w_fs_in[m]) begin
          r_present[m] <= 1'b1;
          r_pcnt[m]    <= '0;
        end else if (r_pcnt[m] == LP_TMAX) begin
          r_present[m] <= 1'b0;
        end else begin
          r_pcnt[m] <= r_pcnt[m] + TIMEOUT_W'(1);
        end
      end
    end
  end

  assign bus.sel_ch0 = r_sel[0];
  assign bus.sel_ch1 = r_sel[1];
  assign bus.sel_ch2 = r_sel[2];
  assign bus.sel_ch3 = r_sel[3];

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      bus.sel_pending[n] = (r_state[n] == ST_WAIT);
    end
  end

  assign bus.sel_done    = r_done;
  assign bus.sel_timeout = r_tmo;
  assign bus.cfg_err     = r_err;
  assign bus.sig_present = r_present;

endmodule

// File: tb/tb_vin_matrix_sel_ctrl.sv
// Directed bench for vin_matrix_sel_ctrl: completion events go through a scoreboard
// queue, cycle timing is checked inline against hand-derived expectations.
module tb_vin_matrix_sel_ctrl;

  logic clk = 1'b0;
  logic rst;

  vin_matrix_sel_ctrl_if bus ();

  vin_matrix_sel_ctrl #(
    .VS_POL    (1'b1),
    .TIMEOUT_W (24),
    .TIMEOUT   (24'd100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  done;
    logic [3:0]  tmo;
    logic        err;
    logic [11:0] sels;
  } ev_t;

  ev_t sb_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] sels_now();
    return {bus.sel_ch3, bus.sel_ch2, bus.sel_ch1, bus.sel_ch0};
  endfunction

  function automatic void expect_ev(input logic [3:0] done, input logic [3:0] tmo,
                                    input logic err, input logic [11:0] sels);
    ev_t e;
    e.done = done;
    e.tmo  = tmo;
    e.err  = err;
    e.sels = sels;
    sb_q.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the next negedge with the write consumed.
  task automatic cfg_write(input logic [1:0] out, input logic [2:0] src);
    bus.cfg_wr  = 1'b1;
    bus.cfg_out = out;
    bus.cfg_src = src;
    @(negedge clk);
    bus.cfg_wr  = 1'b0;
  endtask

  // Scoreboard: every done/err pulse must match the next queued expectation.
  initial begin : monitor
    ev_t obs;
    ev_t exp;
    forever begin
      @(negedge clk);
      if (!rst && ((bus.sel_done != 4'b0) || bus.cfg_err)) begin
        obs = {bus.sel_done, bus.sel_timeout, bus.cfg_err, sels_now()};
        if (sb_q.size() == 0) begin
          check("unexpected_event", 32'(obs), 32'h0);
        end else begin
          exp = sb_q.pop_front();
          check("scoreboard_event", 32'(obs), 32'(exp));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst         = 1'b1;
    bus.cfg_wr  = 1'b0;
    bus.cfg_out = 2'd0;
    bus.cfg_src = 3'd0;
    bus.vs_in   = 5'b0;
    bus.vout_vs = 4'b0;
    step(3);
    rst = 1'b0;

    // Reset state
    check("rst_sels", 32'(sels_now()), 32'h688);
    check("rst_pending", 32'(bus.sel_pending), 32'h0);
    check("rst_present", 32'(bus.sig_present), 32'h0);
    check("rst_done", 32'(bus.sel_done), 32'h0);

    // Output 2 <- input 4, switched on a frame start 30 cycles later
    expect_ev(4'b0100, 4'b0000, 1'b0, 12'h708);
    cfg_write(2'd2, 3'd4);
    check("t2_pending", 32'(bus.sel_pending), 32'h4);
    check("t2_sel_held", 32'(bus.sel_ch2), 32'd2);
    step(29);
    check("t2_before_fs", 32'(bus.sel_ch2), 32'd2);
    bus.vout_vs[2] = 1'b1;
    step(1);
    check("t2_sel", 32'(bus.sel_ch2), 32'd4);
    check("t2_done", 32'(bus.sel_done), 32'h4);
    check("t2_tmo", 32'(bus.sel_timeout), 32'h0);
    check("t2_pending_off", 32'(bus.sel_pending), 32'h0);
    bus.vout_vs[2] = 1'b0;
    step(2);

    // Output 1 <- input 0 with no sync: forced by timeout after 100 cycles
    expect_ev(4'b0010, 4'b0010, 1'b0, 12'h700);
    cfg_write(2'd1, 3'd0);
    step(99);
    check("t3_still_wait", 32'(bus.sel_pending), 32'h2);
    check("t3_sel_held", 32'(bus.sel_ch1), 32'd1);
    step(1);
    check("t3_sel", 32'(bus.sel_ch1), 32'd0);
    check("t3_done", 32'(bus.sel_done), 32'h2);
    check("t3_tmo", 32'(bus.sel_timeout), 32'h2);
    check("t3_pending_off", 32'(bus.sel_pending), 32'h0);
    step(2);

    // Invalid source, then a no-change request
    expect_ev(4'b0000, 4'b0000, 1'b1, 12'h700);
    cfg_write(2'd0, 3'd5);
    check("t4_err", 32'(bus.cfg_err), 32'h1);
    check("t4_err_sels", 32'(sels_now()), 32'h700);
    check("t4_err_pending", 32'(bus.sel_pending), 32'h0);
    step(1);
    check("t4_err_pulse", 32'(bus.cfg_err), 32'h0);
    expect_ev(4'b1000, 4'b0000, 1'b0, 12'h700);
    cfg_write(2'd3, 3'd3);
    check("t4_same_done", 32'(bus.sel_done), 32'h8);
    check("t4_same_pending", 32'(bus.sel_pending), 32'h0);
    step(2);

    // Rewrite while waiting: the latest target is applied
    cfg_write(2'd0, 3'd2);
    step(3);
    expect_ev(4'b0001, 4'b0000, 1'b0, 12'h701);
    cfg_write(2'd0, 3'd1);
    step(4);
    check("t5_pending", 32'(bus.sel_pending), 32'h1);
    bus.vout_vs[0] = 1'b1;
    step(1);
    check("t5_sel_rewrite", 32'(bus.sel_ch0), 32'd1);
    bus.vout_vs[0] = 1'b0;
    step(2);

    // Write in the same cycle as frame start
    cfg_write(2'd0, 3'd3);
    expect_ev(4'b0001, 4'b0000, 1'b0, 12'h704);
    bus.cfg_wr     = 1'b1;
    bus.cfg_out    = 2'd0;
    bus.cfg_src    = 3'd4;
    bus.vout_vs[0] = 1'b1;
    step(1);
    bus.cfg_wr     = 1'b0;
    bus.vout_vs[0] = 1'b0;
    check("t5_sel_same_cycle", 32'(bus.sel_ch0), 32'd4);
    check("t5_done_same_cycle", 32'(bus.sel_done), 32'h1);
    step(2);

    // Frame start on the timeout cycle counts as a normal frame start
    expect_ev(4'b0100, 4'b0000, 1'b0, 12'h684);
    cfg_write(2'd2, 3'd2);
    step(99);
    check("fs_tmo_pending", 32'(bus.sel_pending), 32'h4);
    bus.vout_vs[2] = 1'b1;
    step(1);
    bus.vout_vs[2] = 1'b0;
    check("fs_tmo_sel", 32'(bus.sel_ch2), 32'd2);
    check("fs_tmo_flag", 32'(bus.sel_timeout), 32'h0);
    step(2);

    // Reset while waiting drops the request without a done pulse
    cfg_write(2'd1, 3'd3);
    step(3);
    rst = 1'b1;
    step(1);
    check("rst_wait_sels", 32'(sels_now()), 32'h688);
    check("rst_wait_pending", 32'(bus.sel_pending), 32'h0);
    rst = 1'b0;
    step(2);

    // Presence on input 3
    check("pres_before", 32'(bus.sig_present), 32'h0);
    for (int p = 0; p < 3; p++) begin
      bus.vs_in[3] = 1'b1;
      step(1);
      bus.vs_in[3] = 1'b0;
      check("pres_on", 32'(bus.sig_present), 32'h8);
      if (p < 2) begin
        step(49);
        check("pres_hold", 32'(bus.sig_present), 32'h8);
      end
    end
    step(99);
    check("pres_last_cycle", 32'(bus.sig_present), 32'h8);
    step(1);
    check("pres_lost", 32'(bus.sig_present), 32'h0);

    step(2);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
